// File: rtl/serial_subtractor_controller.sv
// -----------------------------------------------------------------------------
// serial_subtractor_controller
//
// Purpose:
//   Computes diff = (a - b - bin) mod 2^WIDTH one bit per clock, LSB first,
//   using a single mux-based full-subtractor cell. The controller owns the
//   operand shift registers, the borrow flop, the bit counter and the
//   start/busy/done handshake.
//
//   Sequence for an accepted start (edge 0):
//     edge 0         : IDLE  -> LOAD  (operands and bin captured)
//     edge 1         : LOAD  -> SHIFT
//     edges 2..W+1   : SHIFT, one result bit per edge (exactly WIDTH edges)
//     edge W+1       : SHIFT -> DONE  (diff/bout registered on this edge)
//     edge W+2       : DONE  -> IDLE
//   busy is high for WIDTH+1 cycles (LOAD + SHIFT); done pulses for one
//   cycle with busy low.
//
// Parameters:
//   WIDTH : operand/result width, 2..32
//   CNT_W : bit-counter width, derived from WIDTH
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   a      in   minuend, captured on accepted start
//   b      in   subtrahend, captured on accepted start
//   bin    in   initial borrow-in, captured on accepted start
//   busy   out  operation in progress (LOAD or SHIFT)
//   done   out  one-cycle result-valid pulse
//   diff   out  registered result, held until the next operation's DONE
//   bout   out  registered final borrow-out
//   ovf    out  (only with SERIAL_SUB_OVF_EN) two's-complement overflow
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the ovf output and two
// flops holding the captured operand MSBs.
// -----------------------------------------------------------------------------
module serial_subtractor_controller #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Cell truth tables, indexed by sel = {a_bit, b_bit, borrow_in}.
  localparam logic [7:0] DIFF_TBL = 8'b10010110;
  localparam logic [7:0] BORR_TBL = 8'b10001110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  // Holds the WIDTH-1 most recent result bits; the final bit is merged in
  // directly when the result register is loaded.
  logic [WIDTH-2:0]   d_sr_q, d_sr_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;

`ifdef SERIAL_SUB_OVF_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               ovf_q, ovf_d;
`endif

  // ---------------------------------------------------------------------------
  // Full-subtractor cell: two 8:1 muxes built as one-hot AND-OR trees.
  // ---------------------------------------------------------------------------
  logic [2:0] sel;
  logic [7:0] sel_hot;
  logic [7:0] d_terms;
  logic [7:0] b_terms;
  logic       d_bit;
  logic       b_bit;

  assign sel = {a_sr_q[0], b_sr_q[0], borrow_q};

  for (genvar gi = 0; gi < 8; gi++) begin : g_cell_mux
    assign sel_hot[gi] = (sel == 3'(gi));
    assign d_terms[gi] = DIFF_TBL[gi] & sel_hot[gi];
    assign b_terms[gi] = BORR_TBL[gi] & sel_hot[gi];
  end

  assign d_bit = |d_terms;
  assign b_bit = |b_terms;

  // Complete result including the bit produced on this edge.
  logic [WIDTH-1:0] diff_full;
  assign diff_full = {d_bit, d_sr_q};

  logic last_bit;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    d_sr_d   = d_sr_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          d_sr_d   = '0;
          cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        d_sr_d   = diff_full[WIDTH-1:1];
        borrow_d = b_bit;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Load the result registers on the final shift edge so that diff,
          // bout (and ovf) are already valid during the done cycle.
          diff_d  = diff_full;
          bout_d  = b_bit;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // A start here is deliberately not accepted.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
